// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads main memory combinationally and
// buffers {pc, instruction} pairs in a small in-order queue towards decode.
module fetch_unit #(
    parameter logic [31:0] STARTING_ADDR = 32'h01000000,
    parameter int          QUEUE_DEPTH   = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] mem_address,
    output logic        mem_read_write,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    localparam int             PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH = (PTR_W + 1)'(QUEUE_DEPTH);

    logic [31:0]      pc;
    logic [31:0]      q_inst [QUEUE_DEPTH];
    logic [31:0]      q_pc   [QUEUE_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             fault;

    logic pop;
    logic space;
    logic push;

    assign mem_address    = pc;
    assign mem_read_write = 1'b0;
    assign mem_data_in    = 32'h0;

    assign inst_valid  = (count != '0);
    assign inst        = q_inst[head];
    assign inst_pc     = q_pc[head];
    assign fetch_fault = fault;

    // A pop frees a slot in the same cycle, so a full queue still streams 1/cycle.
    assign pop   = inst_valid & inst_ready;
    assign space = (count < DEPTH) | pop;
    assign push  = !redirect_valid & !fault & space;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc    <= STARTING_ADDR;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            fault <= 1'b0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_inst[i] <= 32'h0;
                q_pc[i]   <= 32'h0;
            end
        end else if (redirect_valid) begin
            // Flush squashes any same-cycle handshake as well as buffered entries.
            pc    <= redirect_target;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            if (redirect_target[1:0] != 2'b00) begin
                fault <= 1'b1;
            end
        end else if (!fault) begin
            if (push) begin
                q_inst[tail] <= mem_data_out;
                q_pc[tail]   <= pc;
                tail         <= tail + PTR_W'(1);
                pc           <= pc + 32'd4;
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count <= count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected {pc, inst}
// pairs; a negedge monitor pops and compares on every accepted handshake.
module tb_fetch_unit;

    localparam logic [31:0] START = 32'h01000000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [31:0] mem_address;
    logic        mem_read_write;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    fetch_unit #(.STARTING_ADDR(START), .QUEUE_DEPTH(2)) dut (
        .clock           (clock),
        .reset           (reset),
        .mem_address     (mem_address),
        .mem_read_write  (mem_read_write),
        .mem_data_in     (mem_data_in),
        .mem_data_out    (mem_data_out),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .fetch_fault     (fetch_fault)
    );

    // Memory stub: every word reads as C0DE_xxxx with the low address half.
    assign mem_data_out = {16'hC0DE, mem_address[15:0]};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_pair(input logic [31:0] pc, input logic [31:0] word);
        exp_t e;
        e.pc   = pc;
        e.inst = word;
        exp_q.push_back(e);
    endtask

    always @(negedge clock) begin
        if (!reset && inst_valid && inst_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %h inst %h, required no delivery", inst_pc, inst);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("inst_pc", inst_pc, e.pc);
                chk("inst", inst, e.inst);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reset is raised between edges so its asynchronous effect can be observed.
    task automatic do_reset();
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_addr", mem_address, START);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        inst_ready      = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        do_reset();
        chk("mem_rw", 32'(mem_read_write), 32'd0);
        chk("mem_din", mem_data_in, 32'h0);

        // Streaming with decode always ready
        inst_ready = 1'b1;
        expect_pair(32'h01000000, 32'hC0DE0000);
        expect_pair(32'h01000004, 32'hC0DE0004);
        expect_pair(32'h01000008, 32'hC0DE0008);
        expect_pair(32'h0100000C, 32'hC0DE000C);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stream_valid", 32'(inst_valid), 32'd1);
        end
        do_reset();

        // Back-pressure: queue fills, PC freezes, then drains without gaps
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", 32'(inst_valid), 32'd1);
            chk("stall_pc", inst_pc, 32'h01000000);
        end
        chk("stall_addr", mem_address, 32'h01000008);
        chk("stall_inst", inst, 32'hC0DE0000);
        expect_pair(32'h01000000, 32'hC0DE0000);
        expect_pair(32'h01000004, 32'hC0DE0004);
        expect_pair(32'h01000008, 32'hC0DE0008);
        expect_pair(32'h0100000C, 32'hC0DE000C);
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("drain_valid", 32'(inst_valid), 32'd1);
        end
        do_reset();

        // Redirect on a full queue with a simultaneous handshake
        inst_ready = 1'b0;
        step();
        step();
        chk("full_addr", mem_address, 32'h01000008);
        inst_ready      = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h01000040;
        expect_pair(32'h01000040, 32'hC0DE0040);
        expect_pair(32'h01000044, 32'hC0DE0044);
        expect_pair(32'h01000048, 32'hC0DE0048);
        step();
        redirect_valid = 1'b0;
        chk("flush_valid", 32'(inst_valid), 32'd0);
        chk("redir_addr", mem_address, 32'h01000040);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("redir_valid", 32'(inst_valid), 32'd1);
        end
        do_reset();

        // Misaligned redirect: sticky fault, fetch stops until reset
        redirect_valid  = 1'b1;
        redirect_target = 32'h01000042;
        step();
        redirect_valid = 1'b0;
        chk("fault_set", 32'(fetch_fault), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("fault_valid", 32'(inst_valid), 32'd0);
        end
        chk("fault_addr", mem_address, 32'h01000042);
        chk("fault_sticky", 32'(fetch_fault), 32'd1);
        do_reset();
        expect_pair(32'h01000000, 32'hC0DE0000);
        step();
        chk("resume_valid", 32'(inst_valid), 32'd1);
        do_reset();

        // PC wraps past the top of the address space
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFFFFF8;
        step();
        redirect_valid = 1'b0;
        expect_pair(32'hFFFFFFF8, 32'hC0DEFFF8);
        expect_pair(32'hFFFFFFFC, 32'hC0DEFFFC);
        expect_pair(32'h00000000, 32'hC0DE0000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wrap_valid", 32'(inst_valid), 32'd1);
        end
        do_reset();

        // Asynchronous reset while two entries are buffered
        inst_ready = 1'b0;
        step();
        step();
        chk("pre_rst_valid", 32'(inst_valid), 32'd1);
        chk("pre_rst_addr", mem_address, 32'h01000008);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that drives the word address into the main memory read port and consumes its combinational read data. Holds the program counter, captures {pc, instruction} pairs into a small in-order queue, and presents them to decode over a valid/ready handshake. Supports a redirect for branches and jumps, which flushes the queue. Flags a sticky fault on a misaligned redirect target.

Parameters:
STARTING_ADDR, 32'h01000000, reset PC; must match the main memory base address.
QUEUE_DEPTH, 2, number of instruction queue entries; power of two, at least 2.

Ports:
clock  input  1  single clock; all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
mem_address  output  32  word address to main memory; always equals pc.
mem_read_write  output  1  tied to 0 (READ).
mem_data_in  output  32  tied to 32'h0.
mem_data_out  input  32  combinational read data for mem_address, little-endian word.
redirect_valid  input  1  load a new PC this cycle.
redirect_target  input  32  new PC when redirect_valid is high.
inst_valid  output  1  queue head is valid.
inst_ready  input  1  decode accepts the head this cycle.
inst  output  32  instruction at the queue head.
inst_pc  output  32  PC of the queue head.
fetch_fault  output  1  sticky flag: a misaligned redirect target was received.

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-operation):
  - pc = STARTING_ADDR; queue count = 0; all queue entries = 0; fetch_fault = 0.
  - Outputs therefore read: inst_valid = 0, inst = 0, inst_pc = 0, mem_address = STARTING_ADDR.
- mem_address is driven combinationally from the pc register. Memory read data is valid in the same cycle.
- Definitions:
  - pop = inst_valid & inst_ready.
  - space = (count < QUEUE_DEPTH) | pop.
  - push = !redirect_valid & !fetch_fault & space.
- Per posedge, priority from highest to lowest:
  1. redirect_valid:
     - Flush the queue (count <= 0). Any pop in this cycle is discarded; decode must treat the redirect as squashing it.
     - pc <= redirect_target.
     - If redirect_target[1:0] != 0, set fetch_fault.
     - No push this cycle.
  2. fetch_fault set: the queue is held empty and no pushes occur until reset.
  3. Otherwise:
     - On push, write {pc, mem_data_out} at the tail and set pc <= pc + 4, modulo 2^32, so 32'hFFFFFFFC wraps to 0.
     - On pop, advance the head.
     - count += push - pop.
- Full queue with simultaneous pop: push and pop happen in the same cycle, so throughput stays at 1 instruction per cycle.
- Full queue without pop: pc holds, no push, and mem_address stays stable.
- Empty queue: inst_valid = 0; inst_ready is ignored.
- inst_valid = (count != 0). inst and inst_pc come combinationally from the head entry. They hold stable while inst_valid is high and inst_ready is low.
- Latency:
  - The first posedge after reset deasserts pushes STARTING_ADDR, and inst_valid rises after that edge.
  - After a redirect edge, the first instruction from the target becomes valid one edge later.
- Ordering: strictly in order; no entry is ever duplicated or skipped except by a flush.
- Data: mem_data_out is captured unmodified, X included; the fetch stage does no decode.
- Implementation: the queue is a circular buffer with head/tail pointers of log2(QUEUE_DEPTH) bits that wrap naturally, plus a separate count of log2(QUEUE_DEPTH)+1 bits to distinguish full from empty.

Test Plan:
- Reset release, inst_ready held at 1, memory preloaded with a sequence → inst_pc = 01000000, 01000004, 01000008… on consecutive cycles; inst matches memory; inst_valid is continuous after the first edge.
- inst_ready = 0 for 5 cycles → count saturates at 2; mem_address freezes at 01000008; inst/inst_pc stay at 01000000. Then raise inst_ready → 01000000, 01000004, 01000008 are delivered in order with no gap.
- redirect_valid with target 01000040, queue full, inst_ready = 1 in the same cycle → the queue flushes; the next valid inst_pc = 01000040, then 01000044; the old 01000004 never appears.
- redirect_target = 01000042 → fetch_fault = 1; inst_valid stays 0 for ≥10 cycles; pc holds. Assert reset → fault clears and fetch resumes at 01000000.
- Redirect to FFFFFFF8 with a memory stub covering that region → inst_pc sequence FFFFFFF8, FFFFFFFC, 00000000.
- Assert reset asynchronously between edges while the queue holds 2 entries → inst_valid drops immediately and mem_address = 01000000 before the next posedge.
